// File: rtl/ssd_digit_scanner.sv
// Time-multiplexed driver for a four-digit seven-segment display with dead-time
// blanking and a double-buffered value so a frame never shows a torn update.
module ssd_digit_scanner #(
   parameter int TICK_DIV     = 100000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic        ACLK,
   input  logic        ARESET,
   input  logic        enable,
   input  logic        load,
   input  logic [15:0] value,
   input  logic [3:0]  dp_in,
   input  logic [3:0]  digit_mask,
   output logic [6:0]  seg_n,
   output logic        dp_n,
   output logic [3:0]  an_n,
   output logic        frame_done
);

   localparam int CNT_MAX = (TICK_DIV > BLANK_CYCLES) ? TICK_DIV : BLANK_CYCLES;
   localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
   localparam logic [CW-1:0] DRIVE_LAST = CW'(TICK_DIV - 1);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);

   typedef enum logic [1:0] {S_OFF = 2'd0, S_BLANK = 2'd1, S_DRIVE = 2'd2} state_t;

   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      case (nib)
         4'h0: seg_decode = 7'h40;
         4'h1: seg_decode = 7'h79;
         4'h2: seg_decode = 7'h24;
         4'h3: seg_decode = 7'h30;
         4'h4: seg_decode = 7'h19;
         4'h5: seg_decode = 7'h12;
         4'h6: seg_decode = 7'h02;
         4'h7: seg_decode = 7'h78;
         4'h8: seg_decode = 7'h00;
         4'h9: seg_decode = 7'h10;
         4'hA: seg_decode = 7'h08;
         4'hB: seg_decode = 7'h03;
         4'hC: seg_decode = 7'h46;
         4'hD: seg_decode = 7'h21;
         4'hE: seg_decode = 7'h06;
         4'hF: seg_decode = 7'h0E;
         default: seg_decode = 7'h7F;
      endcase
   endfunction

   // Buffers are packed as {mask, dp, value}.
   state_t          state_q, state_d;
   logic [1:0]      idx_q, idx_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [23:0]     stg_q, stg_d, sh_q, sh_d;
   logic            pend_q, pend_d;
   logic [6:0]      seg_q, seg_d;
   logic            dp_q, dp_d;
   logic [3:0]      an_q, an_d;
   logic            fd_q, fd_d;
   logic [23:0]     in_s;
   logic [3:0]      nib_s;

   assign in_s = {digit_mask, dp_in, value};

   // Next-state: scan sequencing, buffer hand-over, and output values for the next state.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      fd_d    = 1'b0;
      if (!enable) begin
         state_d = S_OFF;
         idx_d   = 2'd0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_OFF: begin
               state_d = S_BLANK;
               idx_d   = 2'd0;
               cnt_d   = '0;
            end
            S_BLANK: begin
               if (cnt_q == BLANK_LAST) begin
                  state_d = S_DRIVE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            S_DRIVE: begin
               if (cnt_q == DRIVE_LAST) begin
                  state_d = S_BLANK;
                  cnt_d   = '0;
                  idx_d   = idx_q + 2'd1;
                  fd_d    = (idx_q == 2'd3);
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_d = S_OFF;
               idx_d   = 2'd0;
               cnt_d   = '0;
            end
         endcase
      end

      stg_d  = load ? in_s : stg_q;
      sh_d   = sh_q;
      pend_d = pend_q;
      if (state_q == S_OFF) begin
         sh_d   = stg_d;
         pend_d = 1'b0;
      end else if (fd_d) begin
         // A load on the frame boundary bypasses the pending path entirely.
         sh_d   = load ? in_s : (pend_q ? stg_q : sh_q);
         pend_d = 1'b0;
      end else begin
         pend_d = pend_q | load;
      end

      nib_s = sh_d[{idx_d, 2'b00} +: 4];
      if (state_d == S_DRIVE) begin
         seg_d = seg_decode(nib_s);
         if (sh_d[20 + {2'b00, idx_d}]) begin
            an_d = ~(4'b0001 << idx_d);
            dp_d = ~sh_d[16 + {2'b00, idx_d}];
         end else begin
            an_d = 4'hF;
            dp_d = 1'b1;
         end
      end else begin
         seg_d = 7'h7F;
         an_d  = 4'hF;
         dp_d  = 1'b1;
      end
   end

   // State, buffer and output registers.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q <= S_OFF;
         idx_q   <= 2'd0;
         cnt_q   <= '0;
         stg_q   <= 24'h000000;
         sh_q    <= 24'h000000;
         pend_q  <= 1'b0;
         seg_q   <= 7'h7F;
         dp_q    <= 1'b1;
         an_q    <= 4'hF;
         fd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         stg_q   <= stg_d;
         sh_q    <= sh_d;
         pend_q  <= pend_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
         an_q    <= an_d;
         fd_q    <= fd_d;
      end
   end

   assign seg_n      = seg_q;
   assign dp_n       = dp_q;
   assign an_n       = an_q;
   assign frame_done = fd_q;

endmodule

// File: tb/tb_ssd_digit_scanner.sv
// Directed bench for ssd_digit_scanner with TICK_DIV=4, BLANK_CYCLES=2 (24-cycle frame).
module tb_ssd_digit_scanner;

   logic        ACLK = 1'b0;
   logic        ARESET;
   logic        enable;
   logic        load;
   logic [15:0] value;
   logic [3:0]  dp_in;
   logic [3:0]  digit_mask;
   logic [6:0]  seg_n;
   logic        dp_n;
   logic [3:0]  an_n;
   logic        frame_done;

   int checks = 0;
   int errors = 0;

   ssd_digit_scanner #(.TICK_DIV(4), .BLANK_CYCLES(2)) dut (
      .ACLK(ACLK), .ARESET(ARESET), .enable(enable), .load(load), .value(value),
      .dp_in(dp_in), .digit_mask(digit_mask), .seg_n(seg_n), .dp_n(dp_n),
      .an_n(an_n), .frame_done(frame_done)
   );

   always #5 ACLK = ~ACLK;

   task automatic step();
      @(posedge ACLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_off(input string tag);
      check({tag, ".an"},  {28'd0, an_n},       {28'd0, 4'hF});
      check({tag, ".seg"}, {25'd0, seg_n},      {25'd0, 7'h7F});
      check({tag, ".dp"},  {31'd0, dp_n},       {31'd0, 1'b1});
      check({tag, ".fd"},  {31'd0, frame_done}, 32'd0);
   endtask

   // segs: slot s expects segs[7s+:7]; optional one-cycle load at cycle load_cyc.
   task automatic run_frame(input string tag, input int ncyc, input logic first_fd,
                            input logic [27:0] segs, input logic [3:0] mask, input logic [3:0] dp,
                            input int load_cyc, input logic [15:0] ld_val, input logic [3:0] ld_mask,
                            input logic [3:0] ld_dp, input logic exp_pend);
      logic [3:0] onehot;
      logic [3:0] exp_an;
      logic [6:0] exp_seg;
      logic       exp_dp;
      logic       exp_fd;
      for (int c = 0; c < ncyc; c++) begin
         int s;
         int ph;
         s  = c / 6;
         ph = c % 6;
         if (c == load_cyc) begin
            load       = 1'b1;
            value      = ld_val;
            digit_mask = ld_mask;
            dp_in      = ld_dp;
         end
         step();
         load   = 1'b0;
         onehot = 4'b0001 << s;
         if (ph >= 2) begin
            exp_seg = segs[s*7 +: 7];
            exp_an  = mask[s] ? ~onehot : 4'hF;
            exp_dp  = (mask[s] && dp[s]) ? 1'b0 : 1'b1;
         end else begin
            exp_seg = 7'h7F;
            exp_an  = 4'hF;
            exp_dp  = 1'b1;
         end
         exp_fd = (c == 0) ? first_fd : 1'b0;
         check($sformatf("%s.c%0d.an", tag, c),  {28'd0, an_n},       {28'd0, exp_an});
         check($sformatf("%s.c%0d.seg", tag, c), {25'd0, seg_n},      {25'd0, exp_seg});
         check($sformatf("%s.c%0d.dp", tag, c),  {31'd0, dp_n},       {31'd0, exp_dp});
         check($sformatf("%s.c%0d.fd", tag, c),  {31'd0, frame_done}, {31'd0, exp_fd});
         if (c == load_cyc) begin
            check($sformatf("%s.pend", tag), {31'd0, dut.pend_q}, {31'd0, exp_pend});
         end
      end
   endtask

   initial begin
      ARESET = 1'b1; enable = 1'b0; load = 1'b0;
      value = 16'h0000; dp_in = 4'h0; digit_mask = 4'h0;
      step();
      step();
      check_off("reset");
      ARESET = 1'b0;
      step();
      check_off("idle");

      // Load 1234 while off, then start scanning.
      load = 1'b1; value = 16'h1234; digit_mask = 4'hF; dp_in = 4'h0;
      step();
      load = 1'b0;
      check_off("load_off");
      enable = 1'b1;
      run_frame("f1", 24, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 4'h0,
                -1, 16'h0, 4'h0, 4'h0, 1'b0);

      // ABCD loaded during digit 1 drive stays pending until frame end.
      run_frame("f2", 24, 1'b1, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 4'h0,
                9, 16'hABCD, 4'hF, 4'h0, 1'b1);
      run_frame("f3", 24, 1'b1, {7'h08, 7'h03, 7'h46, 7'h21}, 4'hF, 4'h0,
                -1, 16'h0, 4'h0, 4'h0, 1'b0);

      // Load on the frame_done edge shows immediately, no pending.
      run_frame("f4", 24, 1'b1, {7'h40, 7'h40, 7'h0E, 7'h40}, 4'hF, 4'h0,
                0, 16'h00F0, 4'hF, 4'h0, 1'b0);

      // Masked digits with a decimal point on digit 0.
      run_frame("f5", 24, 1'b1, {7'h40, 7'h40, 7'h0E, 7'h40}, 4'hF, 4'h0,
                3, 16'h5678, 4'b0101, 4'b0001, 1'b1);
      run_frame("f6", 24, 1'b1, {7'h12, 7'h02, 7'h78, 7'h00}, 4'b0101, 4'b0001,
                -1, 16'h0, 4'h0, 4'h0, 1'b0);

      // Drop enable during digit 2 drive, then restart from digit 0.
      run_frame("f7", 15, 1'b1, {7'h12, 7'h02, 7'h78, 7'h00}, 4'b0101, 4'b0001,
                -1, 16'h0, 4'h0, 4'h0, 1'b0);
      enable = 1'b0;
      step();
      check_off("drop");
      step();
      check_off("drop_hold");
      enable = 1'b1;
      run_frame("reen", 24, 1'b0, {7'h12, 7'h02, 7'h78, 7'h00}, 4'b0101, 4'b0001,
                -1, 16'h0, 4'h0, 4'h0, 1'b0);

      // Reset mid-frame with a simultaneous load.
      run_frame("pre_rst", 10, 1'b1, {7'h12, 7'h02, 7'h78, 7'h00}, 4'b0101, 4'b0001,
                -1, 16'h0, 4'h0, 4'h0, 1'b0);
      ARESET = 1'b1; load = 1'b1; value = 16'hFFFF; digit_mask = 4'hF; dp_in = 4'hF;
      step();
      check_off("rst_mid");
      check("rst_mid.pend", {31'd0, dut.pend_q}, 32'd0);
      ARESET = 1'b0; load = 1'b0;
      run_frame("post_rst", 24, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}, 4'h0, 4'h0,
                -1, 16'h0, 4'h0, 4'h0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ssd_digit_scanner.md
SSD_DIGIT_SCANNER -- requirements
Module: ssd_digit_scanner

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000, meaning DRIVE cycles per digit slot (legal range >=2).
REQ-002 SHALL have parameter BLANK_CYCLES, default 16, meaning the all-off dead-time cycles before each digit slot (legal range >=1).
REQ-003 SHALL have port ACLK, input, 1 bit: the single clock; all logic rising-edge.
REQ-004 SHALL have port ARESET, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port enable, input, 1 bit: scan enable, level.
REQ-006 SHALL have port load, input, 1 bit: single-cycle strobe that captures value, dp_in and digit_mask.
REQ-007 SHALL have port value, input, 16 bits: four hex nibbles; digit i = value[4i+3:4i].
REQ-008 SHALL have port dp_in, input, 4 bits: decimal point per digit, 1 = lit.
REQ-009 SHALL have port digit_mask, input, 4 bits: 1 = digit visible.
REQ-010 SHALL have port seg_n, output, 7 bits: segments {g,f,e,d,c,b,a}, active-low.
REQ-011 SHALL have port dp_n, output, 1 bit: decimal point, active-low.
REQ-012 SHALL have port an_n, output, 4 bits: digit anodes, active-low.
REQ-013 SHALL have port frame_done, output, 1 bit: one-cycle pulse at the end of digit slot 3.

Function
REQ-014 SHALL register all outputs; they change on the same edge as the FSM state or digit index that drives them.
REQ-015 SHALL keep a staging register set and a pending flag; load copies the inputs to staging and sets pending.
REQ-016 SHALL keep a shadow register set that drives the display; while state is OFF, shadow follows staging every cycle and pending clears.
REQ-017 SHALL copy staging to shadow and clear pending on the frame_done edge when pending=1.
REQ-018 SHALL, when load coincides with the frame_done edge, load the new inputs straight into both staging and shadow and leave pending=0.
REQ-019 SHALL implement FSM states OFF, BLANK and DRIVE, with a 2-bit digit index idx and a cycle counter sized clog2(max(TICK_DIV,BLANK_CYCLES)).
REQ-020 SHALL behave as follows in OFF: an_n=4'hF, seg_n=7'h7F, dp_n=1; if enable=1, go to BLANK with idx=0 and counter=0.
REQ-021 SHALL behave as follows in BLANK: outputs all off; after BLANK_CYCLES cycles, go to DRIVE with counter=0.
REQ-022 SHALL behave as follows in DRIVE, for exactly TICK_DIV cycles:
- an_n[idx]=0 only if shadow mask[idx]=1; all other an_n bits 1.
- seg_n = decode(nibble idx).
- dp_n = ~dp[idx], or 1 if masked.
REQ-023 SHALL, at the end of DRIVE, set idx=idx+1 mod 4 and go to BLANK; when idx was 3, pulse frame_done on that edge.
REQ-024 SHALL still spend the full slot time on a masked digit, with an_n all 1 for that slot; frame period = 4*(BLANK_CYCLES+TICK_DIV) cycles.
REQ-025 SHALL, on enable=0 in any state, enter OFF on the next edge: outputs off, idx=0, counter=0, no frame_done pulse.
REQ-026 SHALL decode nibbles to seg_n hex as 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.

Reset
REQ-027 SHALL, on ARESET=1 at any edge including mid-frame, set:
- state=OFF, idx=0, counter=0;
- staging=0, shadow=0, pending=0;
- an_n=4'hF, seg_n=7'h7F, dp_n=1, frame_done=0.
REQ-028 SHALL give ARESET priority over enable and load in the same cycle.

Verification (TICK_DIV=4, BLANK_CYCLES=2)
REQ-029 SHALL cover: OFF, load value=16'h1234, mask=F, dp=0, then enable=1 -> sequence is:
- an_n=F for 2 cycles;
- an_n=E, seg_n=19 for 4 cycles;
- an_n=F for 2 cycles;
- an_n=D, seg_n=30 for 4 cycles;
- then digit 2 (seg_n=24) and digit 3 (seg_n=79);
- frame_done pulses once per 24 cycles.
REQ-030 SHALL cover: load 16'hABCD during digit 1 DRIVE -> digits 2 and 3 still show 2 and 1; after frame_done, digits 0..3 show seg_n 21, 46, 03, 08.
REQ-031 SHALL cover: load 16'h00F0 on the same cycle as frame_done -> the very next DRIVE slot, digit 0, shows seg_n=40, and pending=0.
REQ-032 SHALL cover: mask=4'b0101, dp=4'b0001 -> an_n low only in slots 0 and 2, dp_n=0 only in slot 0, frame period unchanged at 24 cycles.
REQ-033 SHALL cover: enable dropped mid-DRIVE of digit 2 -> all outputs off on the next edge; on re-enable, 2 BLANK cycles, then digit 0.
REQ-034 SHALL cover: ARESET pulsed mid-frame with load asserted -> outputs off and frame_done=0 on the next edge; after release with enable=1, all slots show digit 0 value 0 (seg_n=40).
